// File: rtl/relu_quant_pool.sv
// relu_quant_pool: bias+ReLU+shift/saturate requant then 2x2 stride-2 max pool; in clk rst i_valid i_data i_bias, out o_valid o_data o_frame_done
module relu_quant_pool #(
  parameter int I_BW = 20,
  parameter int B_BW = 8,
  parameter int O_BW = 8,
  parameter int SHIFT = 7,
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic signed [I_BW-1:0] i_data,
  input  logic signed [B_BW-1:0] i_bias,
  output logic                   o_valid,
  output logic [O_BW-1:0]        o_data,
  output logic                   o_frame_done
);
  localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam int LD = IMG_W / 2;
  localparam int LW = LD > 1 ? $clog2(LD) : 1;
  localparam logic [I_BW:0] QMAX = (I_BW+1)'((1 << (O_BW - 1)) - 1);
  logic signed [I_BW:0] s;
  logic [I_BW:0] r;
  logic [O_BW-1:0] q_n, q, hold, m2, lbv, m3;
  logic [O_BW-1:0] lb [LD];
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [LW-1:0] idx;
  logic v, col_end, row_end;
  always_comb begin
    s = (I_BW+1)'(i_data) + (I_BW+1)'(i_bias);
    r = s[I_BW] ? '0 : s >>> SHIFT;
    q_n = r > QMAX ? QMAX[O_BW-1:0] : r[O_BW-1:0];
    idx = LW'(col >> 1);
    lbv = lb[idx];
    m2 = hold > q ? hold : q;
    m3 = m2 > lbv ? m2 : lbv;
    col_end = col == CW'(IMG_W - 1);
    row_end = row == RW'(IMG_H - 1);
  end
  always_ff @(posedge clk) begin
    if (i_valid) q <= q_n;
    if (v && col[0] && !row[0]) lb[idx] <= m2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      col <= '0;
      row <= '0;
      hold <= '0;
      o_valid <= 1'b0;
      o_data <= '0;
      o_frame_done <= 1'b0;
    end else begin
      v <= i_valid;
      o_valid <= v && col[0] && row[0];
      o_frame_done <= v && col_end && row_end;
      if (v) begin
        col <= col_end ? '0 : col + CW'(1);
        if (col_end) row <= row_end ? '0 : row + RW'(1);
        if (!col[0]) hold <= q;
        if (col[0] && row[0]) o_data <= m3;
      end
    end
  end
endmodule

// File: tb/tb_relu_quant_pool.sv
// tb_relu_quant_pool: scoreboard bench running 2x2, 4x4 and 24x24 instances on one shared input stream
module tb_relu_quant_pool;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv = 1'b0;
  logic [19:0] idata = '0;
  logic [7:0] ibias = '0;
  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  typedef struct {int d; bit f; longint due;} exp_t;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int quant(input int d, input int b);
    int t;
    t = d + b;
    if (t < 0) t = 0;
    t = t / 128;
    return t > 127 ? 127 : t;
  endfunction
  function automatic int mx(input int a, input int b);
    return a > b ? a : b;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int W = g == 0 ? 2 : g == 1 ? 4 : 24;
    localparam int N = W * W;
    logic ov, ofd;
    logic [7:0] od;
    relu_quant_pool #(.IMG_W(W), .IMG_H(W)) dut (
      .clk(clk), .rst(rst), .i_valid(iv), .i_data(idata), .i_bias(ibias),
      .o_valid(ov), .o_data(od), .o_frame_done(ofd)
    );
    exp_t sb[$];
    exp_t e;
    int fr[N];
    int p = 0;
    int last = -1;
    int nout = 0;
    int ndone = 0;
    always @(posedge clk) begin
      if (rst) begin
        sb.delete();
        p = 0;
      end else if (iv) begin
        fr[p] = quant($signed(idata), $signed(ibias));
        if ((p / W) % 2 == 1 && (p % W) % 2 == 1)
          sb.push_back('{mx(mx(fr[p], fr[p-1]), mx(fr[p-W], fr[p-W-1])), p == N - 1, cyc + 2});
        p = (p + 1) % N;
      end
    end
    always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_out W=%0d want data=%0d at cyc=%0d, got no output", W, sb[0].d, sb[0].due);
        void'(sb.pop_front());
      end
      if (ov) begin
        nout++;
        last = od;
        if (ofd) ndone++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out W=%0d got data=%0d fd=%0b cyc=%0d, want no output", W, od, ofd, cyc);
        end else begin
          e = sb.pop_front();
          if (od != e.d || ofd != e.f || cyc != e.due) begin
            errors++;
            $display("FAIL out W=%0d got data=%0d fd=%0b cyc=%0d want data=%0d fd=%0b cyc=%0d",
                     W, od, ofd, cyc, e.d, e.f, e.due);
          end
        end
      end else if (ofd) begin
        checks++;
        errors++;
        $display("FAIL stray_frame_done W=%0d got fd=1 without o_valid at cyc=%0d, want 0", W, cyc);
      end
    end
  end
  task automatic chk(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, got, want);
    end
  endtask
  task automatic send(input int d, input int gap);
    @(negedge clk);
    iv = 1'b1;
    idata = 20'(d);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      iv = 1'b0;
      idata = 20'($urandom);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      iv = 1'b0;
    end
  endtask
  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    iv = 1'b1;
    idata = 20'($urandom);
    @(negedge clk);
    rst = 1'b0;
    iv = 1'b0;
  endtask
  int n0, d0;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state_2x2", {u[0].ofd, u[0].ov, u[0].od}, 0);
    chk("rst_state_4x4", {u[1].ofd, u[1].ov, u[1].od}, 0);
    chk("rst_state_24x24", {u[2].ofd, u[2].ov, u[2].od}, 0);
    rst = 1'b0;
    ibias = 8'd0;
    send(1000, 0); send(-500, 0); send(300, 0); send(2000, 0);
    idle(4);
    chk("quant_data", u[0].last, 15);
    chk("quant_count", u[0].nout, 1);
    chk("quant_done", u[0].ndone, 1);
    pulse_rst();
    ibias = 8'd50;
    send(20000, 0); send(-100, 0); send(100, 0); send(0, 0);
    idle(4);
    chk("sat_data", u[0].last, 127);
    for (int mode = 0; mode < 3; mode++) begin
      pulse_rst();
      ibias = 8'd0;
      n0 = u[1].nout;
      d0 = u[1].ndone;
      for (int k = 0; k < 16; k++) send(128 * k, mode == 0 ? 0 : mode == 1 ? 1 : int'($urandom_range(0, 4)));
      idle(4);
      chk("pool4_last", u[1].last, 15);
      chk("pool4_count", u[1].nout - n0, 4);
      chk("pool4_done", u[1].ndone - d0, 1);
    end
    pulse_rst();
    ibias = 8'($urandom);
    for (int k = 0; k < 6; k++) send(int'($urandom_range(0, 40000)) - 20000, 0);
    pulse_rst();
    n0 = u[1].nout;
    d0 = u[1].ndone;
    for (int k = 0; k < 16; k++) send(int'($urandom_range(0, 40000)) - 20000, int'($urandom_range(0, 1)));
    idle(4);
    chk("midrst_count", u[1].nout - n0, 4);
    chk("midrst_done", u[1].ndone - d0, 1);
    pulse_rst();
    ibias = 8'($urandom);
    n0 = u[2].nout;
    d0 = u[2].ndone;
    for (int k = 0; k < 2 * 576; k++) send(int'($urandom_range(0, 40000)) - 20000, 0);
    idle(4);
    chk("b2b_count", u[2].nout - n0, 288);
    chk("b2b_done", u[2].ndone - d0, 2);
    idle(4);
    chk("drain", u[0].sb.size() + u[1].sb.size() + u[2].sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/relu_quant_pool.md
Name: relu_quant_pool

Overview:
- Post-processing stage directly downstream of the convolution MAC array.
- Consumes one signed I_BW-bit convolution sum per valid cycle, in raster order (row-major, left to right).
- Per pixel: adds the per-channel bias, applies ReLU, then requantizes to O_BW bits with an arithmetic shift and saturation.
- Performs 2x2 stride-2 max pooling using a half-row line buffer; emits one pooled pixel per window to the next layer's input buffer.

Parameters:
- I_BW, 20, width of the incoming conv sum (matches the MAC output width).
- B_BW, 8, width of the signed bias.
- O_BW, 8, width of the output pixel.
- SHIFT, 7, arithmetic right shift applied for requantization.
- IMG_W, 24, feature-map width in pixels; must be even.
- IMG_H, 24, feature-map height in pixels; must be even.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  i_data holds a valid conv pixel this cycle.
- i_data  input  I_BW  signed conv sum.
- i_bias  input  B_BW  signed bias; held stable for the whole frame.
- o_valid  output  1  o_data holds a valid pooled pixel this cycle (single-cycle pulse).
- o_data  output  O_BW  pooled pixel; range 0..2^(O_BW-1)-1.
- o_frame_done  output  1  pulses together with the last pooled pixel of a frame.

Behaviour:
- Reset: while rst=1 at a clock edge, the following clear to 0: o_valid, o_data, o_frame_done, the row/col counters, the stage-1 valid flag, and the hold register. Line-buffer contents are not cleared; every entry is written before it is read.
- No backpressure: every i_valid cycle is accepted. Gaps of any length between valid cycles are allowed and do not change results.
- Stage 1 (registered on i_valid):
  - s = sign-extend(i_data) + sign-extend(i_bias), computed at I_BW+1 bits, so it cannot overflow.
  - ReLU: if s<0 then r=0, else r=s.
  - q = r >>> SHIFT (arithmetic shift).
  - If q > 2^(O_BW-1)-1, q saturates to 2^(O_BW-1)-1 (127 by default).
  - q and a stage-1 valid flag are registered.
- Stage 2 (on stage-1 valid), using counters col (0..IMG_W-1) and row (0..IMG_H-1):
  - col even: hold <= q.
  - col odd, row even: linebuf[col>>1] <= max(hold, q). Line-buffer depth is IMG_W/2.
  - col odd, row odd: o_data <= max(hold, q, linebuf[col>>1]); o_valid <= 1.
  - Any other stage-2 cycle: o_valid <= 0 and o_frame_done <= 0; o_data holds its last value.
- Counter advance: col increments per stage-1 valid. At IMG_W-1, col wraps to 0 and row increments. At row=IMG_H-1, col=IMG_W-1, both wrap to 0 and o_frame_done <= 1 together with that o_valid.
- Latency: o_valid rises exactly 2 cycles after the i_valid cycle that carries the bottom-right pixel of the window.
- Throughput: IMG_W*IMG_H/4 outputs per frame, emitted in raster order of the pooled map.
- Back-to-back frames: the next frame's first pixel may arrive the cycle after the previous frame's last pixel, with no bubble required.
- Reset mid-frame: the partial frame is discarded and no stale output is emitted afterwards. The next accepted pixel is treated as (row 0, col 0).
- i_valid during rst: ignored.
- Ties in max: any equal value is correct, since the outputs are identical.

Test Plan:
- Quantization, IMG_W=IMG_H=2, bias=0: inputs 1000, -500, 300, 2000 (q = 7, 0, 2, 15) -> one o_valid with o_data=15, 2 cycles after the 4th input, o_frame_done=1 in the same cycle.
- Saturation and bias, IMG_W=IMG_H=2, bias=50: inputs 20000, -100, 100, 0 (q = 127, 0, 1, 0) -> o_data=127.
- Pooling order, IMG_W=IMG_H=4, bias=0, input k = 128*k for k=0..15 -> outputs 5, 7, 13, 15 in order; o_frame_done only with 15.
- Gapped stream: repeat the 4x4 case with i_valid asserted every other cycle, plus a random-gap run -> identical outputs; each output is exactly 2 cycles after its window's last input.
- Reset mid-frame, 4x4: feed 6 pixels, assert rst for 1 cycle, then feed a full frame -> exactly 4 outputs, all matching the new frame; no o_valid during or right after reset.
- Back-to-back frames, default 24x24 geometry: two frames with no gap, checked against a reference model -> 144 outputs per frame and exactly two o_frame_done pulses.
